// File: rtl/onehot_request_scheduler.sv
// Purpose:      queue rising-edge request strobes on N lines and present them one at a time, round-robin, as a one-hot word.
// Latency:      a rise sampled at edge k on an idle block shows on out/enable after edge k+3.
// Backpressure: each word is held at least HOLD_CYCLES cycles, then until ack (or until timeout when REQ_SCHED_TIMEOUT_EN).
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   req_in[N]    raw asynchronous request lines, a rising edge is one request
//   ack          downstream consumed the current word (level, looked at once the hold has expired)
//   clr_ovf      synchronous clear of the sticky overflow flag
//   out[N]       one-hot word to the encoder, zero when nothing is presented
//   enable       high exactly while out is non-zero
//   pending[N]   queued, not-yet-served requests
//   overflow     sticky: a new request arrived on a line that was already pending
//   timeout      one-cycle pulse when a presented request is dropped for lack of ack
// Optional feature: define REQ_SCHED_TIMEOUT_EN to enable the ack timeout; otherwise timeout is tied 0.
module onehot_request_scheduler #(
    parameter int N           = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         ack,
    input  logic         clr_ovf,
    output logic [N-1:0] out,
    output logic         enable,
    output logic [N-1:0] pending,
    output logic         overflow,
    output logic         timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (HOLD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("onehot_request_scheduler: HOLD_CYCLES and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   s1_q, s2_q, s3_q;
    logic [N-1:0]   pending_q, pending_d;
    logic           overflow_q, overflow_d;
    logic [N-1:0]   out_q, out_d;
    logic           enable_q, enable_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  idx_q, idx_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   req_edge;
    logic [N-1:0]   clr_mask;
    logic           release_now;
    logic           sel_found;
    logic [PW-1:0]  sel_idx;
    logic [PW-1:0]  cand;

`ifdef REQ_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // A level held high produces a single request: only the 0->1 step of the synchronised line counts.
    assign req_edge = s2_q & ~s3_q;

    // Round-robin pick: first pending bit strictly after the last served index, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        enable_d    = enable_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        clr_mask    = '0;
        release_now = 1'b0;
`ifdef REQ_SCHED_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d          = sel_idx;
                    out_d          = '0;
                    out_d[sel_idx] = 1'b1;
                    enable_d       = 1'b1;
                    hold_d         = HW'(HOLD_CYCLES - 1);
                    state_d        = S_PRESENT;
`ifdef REQ_SCHED_TIMEOUT_EN
                    to_cnt_d       = '0;
`endif
                end
            end
            S_PRESENT: begin
                // ack is ignored until the minimum hold has run out.
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (ack) begin
                    release_now = 1'b1;
`ifdef REQ_SCHED_TIMEOUT_EN
                end else if (to_cnt_q == TW'(TIMEOUT)) begin
                    release_now = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_GAP: begin
                // One all-zero cycle so the encoder sees a clean separation between words.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (release_now) begin
            clr_mask[idx_q] = 1'b1;
            ptr_d           = idx_q;
            out_d           = '0;
            enable_d        = 1'b0;
            state_d         = S_GAP;
        end

        // A new request landing on the bit being cleared wins: it stays pending and is not an overflow.
        pending_d = (pending_q & ~clr_mask) | req_edge;
        if (|(req_edge & pending_q & ~clr_mask)) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
            enable_q   <= 1'b0;
            ptr_q      <= PW'(N - 1);
            idx_q      <= '0;
            hold_q     <= '0;
`ifdef REQ_SCHED_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s1_q       <= req_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            enable_q   <= enable_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
`ifdef REQ_SCHED_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign out      = out_q;
    assign enable   = enable_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
`ifdef REQ_SCHED_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule
